// File: rtl/sprite_anim_seq.sv
// Per-character animation sequencer: steps a frame index through a per-state config table and
// emits a registered sprite ID plus done/wrap flags. Optional mirroring support: SPRITE_ANIM_FLIP_EN.
module sprite_anim_seq #(
  parameter int STATE_W     = 4,
  parameter int NUM_STATES  = 8,
  parameter int FRAME_W     = 6,
  parameter int HOLD_W      = 4,
  parameter int ID_W        = 12,
  parameter int BASE_STRIDE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] anim_state,
  input  logic               frame_tick,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [FRAME_W-1:0] cfg_frames,
  input  logic [HOLD_W-1:0]  cfg_hold,
  input  logic               cfg_loop,
`ifdef SPRITE_ANIM_FLIP_EN
  input  logic               facing_left,
  output logic               sprite_flip,
`endif
  output logic [ID_W-1:0]    sprite_id,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               anim_done,
  output logic               anim_wrap
);

  // Table spans the whole state encoding so any index is legal; entries at or above
  // NUM_STATES are never written and always read back as defaults.
  localparam int                 TBL_DEPTH = 1 << STATE_W;
  localparam logic [STATE_W:0]   NUM_ST    = (STATE_W+1)'(NUM_STATES);
  localparam logic [ID_W-1:0]    STRIDE    = ID_W'(BASE_STRIDE);
  localparam logic [FRAME_W-1:0] ONE_FRAME = FRAME_W'(1);
  localparam logic [HOLD_W-1:0]  ONE_HOLD  = HOLD_W'(1);

  logic [FRAME_W-1:0] frames_tbl [TBL_DEPTH];
  logic [HOLD_W-1:0]  hold_tbl   [TBL_DEPTH];
  logic               loop_tbl   [TBL_DEPTH];

  logic [STATE_W-1:0] cur_state;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               cur_ok;
  logic               cfg_ok;
  logic [FRAME_W-1:0] raw_frames;
  logic [HOLD_W-1:0]  raw_hold;
  logic [FRAME_W-1:0] eff_frames;
  logic [HOLD_W-1:0]  eff_hold;
  logic               eff_loop;
  logic               restart;
  logic               step;
  logic [HOLD_W:0]    hold_next;
  logic [FRAME_W:0]   frame_next;
  logic               hold_end;
  logic               frame_end;
  logic [ID_W-1:0]    id_next;

  assign cur_ok = ({1'b0, cur_state} < NUM_ST);
  assign cfg_ok = ({1'b0, cfg_state} < NUM_ST);

  always_comb begin
    raw_frames = ONE_FRAME;
    raw_hold   = ONE_HOLD;
    eff_loop   = 1'b1;
    if (cur_ok) begin
      raw_frames = frames_tbl[cur_state];
      raw_hold   = hold_tbl[cur_state];
      eff_loop   = loop_tbl[cur_state];
    end
  end

  assign eff_frames = (raw_frames == '0) ? ONE_FRAME : raw_frames;
  assign eff_hold   = (raw_hold == '0) ? ONE_HOLD : raw_hold;

  // A state change wins over a coincident tick; ticks after a one-shot finishes are inert.
  assign restart    = (anim_state != cur_state);
  assign step       = frame_tick && !restart && !anim_done;
  assign hold_next  = {1'b0, hold_cnt} + {{HOLD_W{1'b0}}, 1'b1};
  assign frame_next = {1'b0, anim_frame} + {{FRAME_W{1'b0}}, 1'b1};
  // Using >= tests keeps things sane if the table shrinks under a running animation.
  assign hold_end   = !(hold_next < {1'b0, eff_hold});
  assign frame_end  = !(frame_next < {1'b0, eff_frames});

  assign id_next = cur_ok ? (ID_W'(cur_state) * STRIDE + ID_W'(anim_frame)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        frames_tbl[i] <= ONE_FRAME;
        hold_tbl[i]   <= ONE_HOLD;
        loop_tbl[i]   <= 1'b1;
      end
    end else if (cfg_we && cfg_ok) begin
      frames_tbl[cfg_state] <= cfg_frames;
      hold_tbl[cfg_state]   <= cfg_hold;
      loop_tbl[cfg_state]   <= cfg_loop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= '0;
      anim_frame <= '0;
      hold_cnt   <= '0;
      anim_done  <= 1'b0;
      anim_wrap  <= 1'b0;
      sprite_id  <= '0;
    end else begin
      anim_wrap <= 1'b0;
      sprite_id <= id_next;
      if (restart) begin
        cur_state  <= anim_state;
        anim_frame <= '0;
        hold_cnt   <= '0;
        anim_done  <= 1'b0;
      end else if (step) begin
        if (!hold_end) begin
          hold_cnt <= hold_next[HOLD_W-1:0];
        end else begin
          hold_cnt <= '0;
          if (!frame_end) begin
            anim_frame <= frame_next[FRAME_W-1:0];
          end else if (eff_loop) begin
            anim_frame <= '0;
            anim_wrap  <= 1'b1;
          end else begin
            anim_done <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SPRITE_ANIM_FLIP_EN
  // Facing is latched only at frame boundaries so a sprite never mirrors mid-frame;
  // the second stage lines it up with sprite_id.
  logic flip_lat;
  logic frame_move;

  assign frame_move = step && hold_end && (!frame_end || eff_loop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_lat    <= 1'b0;
      sprite_flip <= 1'b0;
    end else begin
      if (restart || frame_move) flip_lat <= facing_left;
      sprite_flip <= flip_lat;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq; flip checks build only when SPRITE_ANIM_FLIP_EN is defined.
module tb_sprite_anim_seq;

  logic        clk;
  logic        rst_n;
  logic [3:0]  anim_state;
  logic        frame_tick;
  logic        cfg_we;
  logic [3:0]  cfg_state;
  logic [5:0]  cfg_frames;
  logic [3:0]  cfg_hold;
  logic        cfg_loop;
  logic [11:0] sprite_id;
  logic [5:0]  anim_frame;
  logic        anim_done;
  logic        anim_wrap;
`ifdef SPRITE_ANIM_FLIP_EN
  logic        facing_left;
  logic        sprite_flip;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sprite_anim_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anim_state (anim_state),
    .frame_tick (frame_tick),
    .cfg_we     (cfg_we),
    .cfg_state  (cfg_state),
    .cfg_frames (cfg_frames),
    .cfg_hold   (cfg_hold),
    .cfg_loop   (cfg_loop),
`ifdef SPRITE_ANIM_FLIP_EN
    .facing_left(facing_left),
    .sprite_flip(sprite_flip),
`endif
    .sprite_id  (sprite_id),
    .anim_frame (anim_frame),
    .anim_done  (anim_done),
    .anim_wrap  (anim_wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock edge, then settle 1 ns past it before sampling or driving
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [3:0] st, input logic [5:0] fr, input logic [3:0] hd,
                           input logic lp);
    cfg_we = 1'b1; cfg_state = st; cfg_frames = fr; cfg_hold = hd; cfg_loop = lp;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    int exp_f3 [10];
    int exp_d3 [10];
    int exp_f1 [7];
    int exp_w1 [7];
    exp_f3 = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
    exp_d3 = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    exp_f1 = '{1, 2, 0, 1, 2, 0, 1};
    exp_w1 = '{0, 0, 1, 0, 0, 1, 0};

    rst_n = 1'b0; anim_state = '0; frame_tick = 1'b0; cfg_we = 1'b0;
    cfg_state = '0; cfg_frames = '0; cfg_hold = '0; cfg_loop = 1'b0;
`ifdef SPRITE_ANIM_FLIP_EN
    facing_left = 1'b0;
`endif
    #12;
    check("rst_sprite_id", 32'(sprite_id), 32'h0);
    check("rst_frame", 32'(anim_frame), 32'h0);
    check("rst_done", 32'(anim_done), 32'h0);
    check("rst_wrap", 32'(anim_wrap), 32'h0);
    rst_n = 1'b1;
    cyc();

    // default table: every tick wraps a 1-frame loop
    for (int k = 0; k < 2; k++) begin
      tick_once();
      check("def_wrap", 32'(anim_wrap), 32'h1);
      check("def_frame", 32'(anim_frame), 32'h0);
      check("def_done", 32'(anim_done), 32'h0);
      cyc();
      check("def_wrap_clr", 32'(anim_wrap), 32'h0);
      check("def_sprite_id", 32'(sprite_id), 32'h000);
    end

    // one-shot: state 3, 4 frames, hold 2
    write_cfg(4'd3, 6'd4, 4'd2, 1'b0);
    anim_state = 4'd3;
    cyc();
    check("s3_restart_frame", 32'(anim_frame), 32'h0);
    check("s3_id_lag", 32'(sprite_id), 32'h000);
    frame_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("s3_frame", 32'(anim_frame), 32'(exp_f3[k]));
      check("s3_done", 32'(anim_done), 32'(exp_d3[k]));
      check("s3_id", 32'(sprite_id), 32'h030 + 32'(k == 0 ? 0 : exp_f3[k-1]));
    end
    frame_tick = 1'b0;
    cyc();
    check("s3_id_hold", 32'(sprite_id), 32'h033);
    check("s3_done_hold", 32'(anim_done), 32'h1);

    // looping: state 1, 3 frames, hold 1
    write_cfg(4'd1, 6'd3, 4'd1, 1'b1);
    anim_state = 4'd1;
    cyc();
    check("s1_done_clr", 32'(anim_done), 32'h0);
    for (int k = 0; k < 7; k++) begin
      tick_once();
      check("s1_frame", 32'(anim_frame), 32'(exp_f1[k]));
      check("s1_wrap", 32'(anim_wrap), 32'(exp_w1[k]));
    end

    // restart 3 -> 4 mid-animation with a coincident tick
    anim_state = 4'd3;
    cyc();
    for (int k = 0; k < 3; k++) tick_once();
    check("s3_mid_frame", 32'(anim_frame), 32'h1);
    anim_state = 4'd4;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("s4_frame", 32'(anim_frame), 32'h0);
    check("s4_done", 32'(anim_done), 32'h0);
    check("s4_wrap_none", 32'(anim_wrap), 32'h0);
    check("s4_id_lag", 32'(sprite_id), 32'h031);
    cyc();
    check("s4_id", 32'(sprite_id), 32'h040);
    tick_once();
    check("s4_wrap", 32'(anim_wrap), 32'h1);

    // frames=0 and hold=0 behave as 1: one-shot finishes on the first tick
    write_cfg(4'd2, 6'd0, 4'd0, 1'b0);
    anim_state = 4'd2;
    cyc();
    tick_once();
    check("s2_done", 32'(anim_done), 32'h1);
    check("s2_frame", 32'(anim_frame), 32'h0);
    check("s2_wrap", 32'(anim_wrap), 32'h0);
    cyc();
    check("s2_id", 32'(sprite_id), 32'h020);

    // writes above NUM_STATES are dropped; out-of-range state uses defaults and id 0
    write_cfg(4'd9, 6'd2, 4'd1, 1'b0);
    anim_state = 4'd9;
    cyc();
    cyc();
    check("oor_id", 32'(sprite_id), 32'h0);
    tick_once();
    check("oor_wrap", 32'(anim_wrap), 32'h1);
    check("oor_frame", 32'(anim_frame), 32'h0);
    check("oor_done", 32'(anim_done), 32'h0);

    // async reset while a one-shot is done
    anim_state = 4'd2;
    cyc();
    tick_once();
    check("pre_rst_done", 32'(anim_done), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_id", 32'(sprite_id), 32'h0);
    check("arst_done", 32'(anim_done), 32'h0);
    check("arst_frame", 32'(anim_frame), 32'h0);
    anim_state = 4'd3;
    #2;
    rst_n = 1'b1;
    cyc();
    cyc();
    check("post_rst_id", 32'(sprite_id), 32'h030);
    tick_once();
    check("post_rst_wrap", 32'(anim_wrap), 32'h1);
    check("post_rst_done", 32'(anim_done), 32'h0);

`ifdef SPRITE_ANIM_FLIP_EN
    // flip only follows facing_left at frame boundaries
    write_cfg(4'd5, 6'd4, 4'd3, 1'b1);
    facing_left = 1'b1;
    anim_state = 4'd5;
    cyc();
    cyc();
    check("flip_restart", 32'(sprite_flip), 32'h1);
    facing_left = 1'b0;
    tick_once();
    cyc();
    check("flip_hold1", 32'(sprite_flip), 32'h1);
    tick_once();
    cyc();
    check("flip_hold2", 32'(sprite_flip), 32'h1);
    tick_once();
    check("flip_adv_frame", 32'(anim_frame), 32'h1);
    check("flip_lag", 32'(sprite_flip), 32'h1);
    cyc();
    check("flip_adv", 32'(sprite_flip), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
